// File: rtl/cpu_pkg.sv
// ---------------------------------------------------------------------------
// cpu_pkg
// Shared definitions for the small CPU datapath/control slice.
//   PC_W_DEFAULT    : default program counter width (instruction indices)
//   INSTR_W_DEFAULT : default instruction word width
//   fetch_state_t   : state encoding of the fetch/issue/update controller
//   state_is_busy() : true for every state that is part of an active
//                     instruction loop (neither IDLE nor HALT)
// ---------------------------------------------------------------------------
package cpu_pkg;

  localparam int PC_W_DEFAULT    = 10;
  localparam int INSTR_W_DEFAULT = 16;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_FETCH    = 3'd1,
    ST_WAIT_MEM = 3'd2,
    ST_ISSUE    = 3'd3,
    ST_EXEC     = 3'd4,
    ST_UPDATE   = 3'd5,
    ST_HALT     = 3'd6
  } fetch_state_t;

  // The busy flag is registered from the next state, so this helper is
  // evaluated on state_d rather than on the current state.
  function automatic logic state_is_busy(input fetch_state_t s);
    return !((s == ST_IDLE) || (s == ST_HALT));
  endfunction

endpackage

// File: rtl/fetch_ctrl.sv
// ---------------------------------------------------------------------------
// fetch_ctrl
// Instruction fetch / issue / PC-update sequencer. The program counter
// register lives outside this block; fetch_ctrl only reads it (pc_curr,
// pc_inc) and tells it when and what to load (pc_we, pc_next).
//
// One instruction walks IDLE -> FETCH -> WAIT_MEM -> ISSUE -> EXEC ->
// UPDATE -> FETCH ..., or UPDATE -> HALT when the execute stage asks to
// stop. The shortest loop is five cycles.
//
// Ports
//   clk, rst      : clock, synchronous active-high reset
//   start         : leave IDLE (ignored everywhere else)
//   pc_curr       : current PC
//   pc_inc        : pc_curr + 1, supplied by the PC block
//   pc_we         : PC write enable, only ever high in UPDATE
//   pc_next       : value to load into the PC (pc_inc whenever pc_we=0)
//   imem_req      : one-cycle read request, high in FETCH
//   imem_addr     : read address, always pc_curr
//   imem_valid    : read data valid, honoured only in WAIT_MEM
//   imem_rdata    : read data
//   instr_valid   : instruction offered to execute (ISSUE)
//   instr         : held instruction word
//   instr_ready   : execute stage accepts instr
//   exec_done     : execute finished; qualifies br_taken/br_offset/halt_req
//   br_taken      : branch taken
//   br_offset     : signed two's-complement branch offset
//   halt_req      : stop after the current instruction
//   busy          : controller is inside an instruction loop
//   halted        : controller is in HALT
// ---------------------------------------------------------------------------
module fetch_ctrl
  import cpu_pkg::*;
#(
  parameter int PC_W    = PC_W_DEFAULT,
  parameter int INSTR_W = INSTR_W_DEFAULT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [PC_W-1:0]    pc_curr,
  input  logic [PC_W-1:0]    pc_inc,
  output logic               pc_we,
  output logic [PC_W-1:0]    pc_next,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic               imem_valid,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               instr_valid,
  output logic [INSTR_W-1:0] instr,
  input  logic               instr_ready,
  input  logic               exec_done,
  input  logic               br_taken,
  input  logic [PC_W-1:0]    br_offset,
  input  logic               halt_req,
  output logic               busy,
  output logic               halted
);

  fetch_state_t        state_q, state_d;
  logic [INSTR_W-1:0]  instr_q, instr_d;
  logic                br_taken_q, br_taken_d;
  logic [PC_W-1:0]     br_offset_q, br_offset_d;
  logic                halt_q, halt_d;

  logic                pc_we_q;
  logic                imem_req_q;
  logic                instr_valid_q;
  logic                busy_q;
  logic                halted_q;

  logic [PC_W-1:0]     br_target;

  // Next-state and capture logic. imem_valid only matters in WAIT_MEM and
  // start only in IDLE, so stray pulses elsewhere fall through to the
  // default hold. The branch/halt capture happens on the EXEC cycle that
  // sees exec_done, so the execute stage may drop those inputs afterwards.
  always_comb begin
    state_d     = state_q;
    instr_d     = instr_q;
    br_taken_d  = br_taken_q;
    br_offset_d = br_offset_q;
    halt_d      = halt_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_FETCH;
        end
      end

      ST_FETCH: begin
        state_d = ST_WAIT_MEM;
      end

      ST_WAIT_MEM: begin
        if (imem_valid) begin
          instr_d = imem_rdata;
          state_d = ST_ISSUE;
        end
      end

      ST_ISSUE: begin
        if (instr_ready) begin
          state_d = ST_EXEC;
        end
      end

      ST_EXEC: begin
        if (exec_done) begin
          br_taken_d  = br_taken;
          br_offset_d = br_offset;
          halt_d      = halt_req;
          state_d     = ST_UPDATE;
        end
      end

      ST_UPDATE: begin
        // A pending halt beats a pending branch: the PC is left pointing
        // at the halting instruction.
        if (halt_q) begin
          state_d = ST_HALT;
        end else begin
          state_d = ST_FETCH;
        end
      end

      ST_HALT: begin
        state_d = ST_HALT;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and registered outputs. Every output flag is decoded from the
  // next state so it lines up exactly with the state it describes, without
  // a combinational path from state_q to the pins. Reset wins over every
  // other input and also drops an outstanding memory read, because the
  // controller simply returns to IDLE where imem_valid is not looked at.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      instr_q       <= '0;
      br_taken_q    <= 1'b0;
      br_offset_q   <= '0;
      halt_q        <= 1'b0;
      pc_we_q       <= 1'b0;
      imem_req_q    <= 1'b0;
      instr_valid_q <= 1'b0;
      busy_q        <= 1'b0;
      halted_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      instr_q       <= instr_d;
      br_taken_q    <= br_taken_d;
      br_offset_q   <= br_offset_d;
      halt_q        <= halt_d;
      pc_we_q       <= (state_d == ST_UPDATE) && !halt_d;
      imem_req_q    <= (state_d == ST_FETCH);
      instr_valid_q <= (state_d == ST_ISSUE);
      busy_q        <= state_is_busy(state_d);
      halted_q      <= (state_d == ST_HALT);
    end
  end

  // Branch target: the PC_W-bit sum naturally wraps modulo 2^PC_W, which
  // is what a two's-complement offset needs for both forward and backward
  // branches.
  assign br_target = pc_curr + br_offset_q;

  // pc_next falls back to pc_inc whenever no write is happening, so the
  // PC block sees a sensible value even though it ignores it.
  assign pc_next     = (pc_we_q && br_taken_q) ? br_target : pc_inc;
  assign pc_we       = pc_we_q;
  assign imem_req    = imem_req_q;
  assign imem_addr   = pc_curr;
  assign instr_valid = instr_valid_q;
  assign instr       = instr_q;
  assign busy        = busy_q;
  assign halted      = halted_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// ---------------------------------------------------------------------------
// tb_fetch_ctrl
// Self-checking bench for fetch_ctrl. The bench plays the program counter,
// the instruction memory and the execute stage. A tiny reference model
// (modelPc plus plain modular arithmetic on signed offsets) predicts where
// each instruction should send the PC; handshake timing is driven with
// randomized delays and random junk on every input the controller must
// ignore at that moment.
// ---------------------------------------------------------------------------
module tb_fetch_ctrl;

  localparam int PCW  = 10;
  localparam int IW   = 16;
  localparam int PMOD = 1 << PCW;

  logic            clk;
  logic            rst;
  logic            start;
  logic [PCW-1:0]  pc_curr;
  logic [PCW-1:0]  pc_inc;
  logic            pc_we;
  logic [PCW-1:0]  pc_next;
  logic            imem_req;
  logic [PCW-1:0]  imem_addr;
  logic            imem_valid;
  logic [IW-1:0]   imem_rdata;
  logic            instr_valid;
  logic [IW-1:0]   instr;
  logic            instr_ready;
  logic            exec_done;
  logic            br_taken;
  logic [PCW-1:0]  br_offset;
  logic            halt_req;
  logic            busy;
  logic            halted;

  logic [PCW-1:0]  pcReg;
  logic            pcLoad;
  logic [PCW-1:0]  pcLoadVal;
  bit              monitorOn;

  int              checks;
  int              failures;
  int              modelPc;

  fetch_ctrl #(.PC_W(PCW), .INSTR_W(IW)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .pc_curr     (pc_curr),
    .pc_inc      (pc_inc),
    .pc_we       (pc_we),
    .pc_next     (pc_next),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_valid  (imem_valid),
    .imem_rdata  (imem_rdata),
    .instr_valid (instr_valid),
    .instr       (instr),
    .instr_ready (instr_ready),
    .exec_done   (exec_done),
    .br_taken    (br_taken),
    .br_offset   (br_offset),
    .halt_req    (halt_req),
    .busy        (busy),
    .halted      (halted)
  );

  // Free-running clock, period 10.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Stand-in for the external PC register that sits beside fetch_ctrl.
  always @(posedge clk) begin
    if (pcLoad) pcReg <= pcLoadVal;
    else if (pc_we) pcReg <= pc_next;
  end

  assign pc_curr = pcReg;
  assign pc_inc  = pcReg + 10'd1;

  // Single comparison point for the whole bench.
  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Every-cycle invariants: address follows the PC, and pc_next shows
  // pc_inc whenever no write is taking place.
  always @(negedge clk) begin
    if (monitorOn) begin
      checkOutput("imem_addr_eq_pc", 32'(imem_addr), 32'(pc_curr));
      if (pc_we !== 1'b1) checkOutput("pc_next_idle", 32'(pc_next), 32'(pc_inc));
    end
  end

  // Random values on execute-side inputs while exec_done is low; the
  // controller must not look at them.
  task automatic junkExec();
    br_taken  = 1'($urandom_range(0, 1));
    br_offset = 10'($urandom);
    halt_req  = 1'($urandom_range(0, 1));
    start     = 1'($urandom_range(0, 1));
  endtask

  // Reset, preload the PC and start from IDLE; returns in the FETCH cycle.
  // start is held high during reset to show reset takes priority.
  task automatic startAt(input int pc);
    rst         = 1'b1;
    start       = 1'b1;
    pcLoad      = 1'b1;
    pcLoadVal   = 10'(pc);
    exec_done   = 1'b0;
    instr_ready = 1'b0;
    imem_valid  = 1'($urandom_range(0, 1));
    @(negedge clk);
    rst     = 1'b0;
    pcLoad  = 1'b0;
    modelPc = pc;
    checkOutput("rst_busy",   32'(busy), 32'd0);
    checkOutput("rst_outs",   32'({imem_req, instr_valid, pc_we, halted}), 32'd0);
    checkOutput("rst_instr",  32'(instr), 32'd0);
    start      = 1'b1;
    imem_valid = 1'($urandom_range(0, 1));
    @(negedge clk);
    start = 1'b0;
  endtask

  // Walk one instruction through the controller and check it against the
  // model. Entered at a negedge where FETCH is expected (now or soon).
  task automatic applyStimulus(input int memDelay, input int readyDelay,
                               input int doneDelay, input logic brT,
                               input logic [PCW-1:0] brOff, input logic haltR,
                               input logic [IW-1:0] word);
    int guard;
    int sOff;
    int expPc;
    guard = 0;
    while (imem_req !== 1'b1 && guard < 20) begin
      imem_valid = 1'b0;
      junkExec();
      @(negedge clk);
      guard++;
    end
    if (imem_req !== 1'b1) begin
      checkOutput("fetch_timeout", 32'd0, 32'd1);
      return;
    end
    checkOutput("fetch_addr", 32'(imem_addr), 32'(modelPc));
    checkOutput("fetch_busy", 32'(busy), 32'd1);

    sOff = brOff[PCW-1] ? int'(brOff) - PMOD : int'(brOff);
    if (brT) expPc = (((modelPc + sOff) % PMOD) + PMOD) % PMOD;
    else     expPc = (modelPc + 1) % PMOD;

    // FETCH cycle: a valid here must be ignored.
    imem_valid = 1'($urandom_range(0, 1));
    imem_rdata = 16'($urandom);
    junkExec();
    @(negedge clk);

    // WAIT_MEM: request must already be gone, data arrives after memDelay.
    for (int i = 0; i <= memDelay; i++) begin
      checkOutput("wait_outs", 32'({imem_req, instr_valid, pc_we}), 32'd0);
      if (i == memDelay) begin
        imem_valid = 1'b1;
        imem_rdata = word;
      end else begin
        imem_valid = 1'b0;
        imem_rdata = 16'($urandom);
      end
      junkExec();
      @(negedge clk);
    end

    // ISSUE: instruction held and offered until accepted.
    for (int i = 0; i <= readyDelay; i++) begin
      imem_valid = 1'($urandom_range(0, 1));
      imem_rdata = ~word;
      checkOutput("issue_valid", 32'(instr_valid), 32'd1);
      checkOutput("issue_instr", 32'(instr), 32'(word));
      checkOutput("issue_outs",  32'({imem_req, pc_we}), 32'd0);
      instr_ready = (i == readyDelay);
      junkExec();
      @(negedge clk);
    end
    instr_ready = 1'b0;

    // EXEC: wait for exec_done, then present the real branch/halt info.
    for (int i = 0; i <= doneDelay; i++) begin
      imem_valid = 1'($urandom_range(0, 1));
      checkOutput("exec_outs",  32'({imem_req, instr_valid, pc_we}), 32'd0);
      checkOutput("exec_instr", 32'(instr), 32'(word));
      junkExec();
      if (i == doneDelay) begin
        exec_done = 1'b1;
        br_taken  = brT;
        br_offset = brOff;
        halt_req  = haltR;
      end
      @(negedge clk);
    end
    exec_done = 1'b0;
    junkExec();

    // UPDATE: captured values drive the PC write, not the current inputs.
    if (haltR) begin
      checkOutput("update_we_halt",   32'(pc_we), 32'd0);
      checkOutput("update_next_halt", 32'(pc_next), 32'((modelPc + 1) % PMOD));
    end else begin
      checkOutput("update_we",   32'(pc_we), 32'd1);
      checkOutput("update_next", 32'(pc_next), 32'(expPc));
    end
    checkOutput("update_instr", 32'(instr), 32'(word));
    @(negedge clk);

    if (haltR) begin
      checkOutput("halt_flags", 32'({halted, busy}), 32'b10);
      checkOutput("halt_outs",  32'({imem_req, instr_valid, pc_we}), 32'd0);
      checkOutput("halt_pc",    32'(pc_curr), 32'(modelPc));
    end else begin
      modelPc = expPc;
      checkOutput("loop_pc",    32'(pc_curr), 32'(modelPc));
      checkOutput("loop_fetch", 32'(imem_req), 32'd1);
    end
  endtask

  // Scenario sequence.
  initial begin
    checks      = 0;
    failures    = 0;
    monitorOn   = 1'b0;
    rst         = 1'b1;
    start       = 1'b0;
    pcLoad      = 1'b1;
    pcLoadVal   = '0;
    imem_valid  = 1'b0;
    imem_rdata  = '0;
    instr_ready = 1'b0;
    exec_done   = 1'b0;
    br_taken    = 1'b0;
    br_offset   = '0;
    halt_req    = 1'b0;
    modelPc     = 0;
    repeat (2) @(negedge clk);
    checkOutput("reset_flags", 32'({busy, halted, imem_req, instr_valid, pc_we}), 32'd0);
    checkOutput("reset_instr", 32'(instr), 32'd0);
    monitorOn = 1'b1;

    // Minimum loop from PC 0 fetching 0xA5A5.
    startAt(0);
    applyStimulus(0, 0, 0, 1'b0, 10'd0, 1'b0, 16'hA5A5);

    // Backward branch 5 + (-3) = 2.
    startAt(5);
    applyStimulus(0, 0, 0, 1'b1, 10'h3FD, 1'b0, 16'h1111);

    // Sequential wrap at the top of the address space.
    startAt(1023);
    applyStimulus(0, 0, 0, 1'b0, 10'd0, 1'b0, 16'h2222);

    // Forward branch wrapping 1020 + 8 = 4.
    startAt(1020);
    applyStimulus(1, 0, 0, 1'b1, 10'd8, 1'b0, 16'h3333);

    // Slow memory and slow execute stage.
    applyStimulus(4, 3, 2, 1'b0, 10'd0, 1'b0, 16'h4444);

    // Random instruction stream, finished by a halt that also branches.
    startAt(int'($urandom_range(0, PMOD - 1)));
    for (int n = 0; n < 30; n++) begin
      applyStimulus(int'($urandom_range(0, 4)), int'($urandom_range(0, 4)),
                    int'($urandom_range(0, 4)), 1'($urandom_range(0, 1)),
                    10'($urandom), 1'b0, 16'($urandom));
    end
    applyStimulus(0, 1, 0, 1'b1, 10'd17, 1'b1, 16'hDEAD);

    // HALT is sticky and ignores start.
    for (int n = 0; n < 4; n++) begin
      start = 1'b1;
      imem_valid = 1'($urandom_range(0, 1));
      @(negedge clk);
      checkOutput("halt_sticky", 32'({halted, busy, imem_req, pc_we}), 32'b1000);
    end
    start = 1'b0;

    // Reset during WAIT_MEM; the late read response must be dropped.
    startAt(100);
    applyStimulus(0, 0, 0, 1'b0, 10'd0, 1'b0, 16'hBEEF);
    imem_valid = 1'b0;
    @(negedge clk);
    checkOutput("pre_rst_wait", 32'({busy, imem_req}), 32'b10);
    rst        = 1'b1;
    start      = 1'b0;
    imem_valid = 1'b0;
    @(negedge clk);
    rst        = 1'b0;
    imem_valid = 1'b1;
    imem_rdata = 16'h1234;
    checkOutput("rst_wait_busy", 32'(busy), 32'd0);
    @(negedge clk);
    imem_valid = 1'b0;
    checkOutput("late_valid_flags", 32'({busy, halted, imem_req, instr_valid}), 32'd0);
    checkOutput("late_valid_instr", 32'(instr), 32'd0);
    @(negedge clk);
    checkOutput("still_idle", 32'({busy, imem_req, instr_valid}), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Hard stop in case a scenario ever wedges.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 SHALL have parameter PC_W, default 10, program counter width in instruction indices.
REQ-002 SHALL have parameter INSTR_W, default 16, instruction word width.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port start, input, 1 bit: leave IDLE and begin execution.
REQ-006 SHALL have port pc_curr, input, PC_W bits: current PC from the program counter.
REQ-007 SHALL have port pc_inc, input, PC_W bits: pc_curr+1 from the program counter.
REQ-008 SHALL have port pc_we, output, 1 bit: PC write enable.
REQ-009 SHALL have port pc_next, output, PC_W bits: next PC value.
REQ-010 SHALL have port imem_req, output, 1 bit: instruction memory read request pulse.
REQ-011 SHALL have port imem_addr, output, PC_W bits: read address.
REQ-012 SHALL have port imem_valid, input, 1 bit: read data valid.
REQ-013 SHALL have port imem_rdata, input, INSTR_W bits: read data.
REQ-014 SHALL have port instr_valid, output, 1 bit: instruction offered to the execute stage.
REQ-015 SHALL have port instr, output, INSTR_W bits: the held instruction.
REQ-016 SHALL have port instr_ready, input, 1 bit: the execute stage accepts instr.
REQ-017 SHALL have port exec_done, input, 1 bit: the execute stage finished; br_taken, br_offset and halt_req are qualified by it.
REQ-018 SHALL have port br_taken, input, 1 bit: branch taken.
REQ-019 SHALL have port br_offset, input, PC_W bits: signed two's-complement branch offset.
REQ-020 SHALL have port halt_req, input, 1 bit: stop after the current instruction.
REQ-021 SHALL have port busy, output, 1 bit: state is neither IDLE nor HALT.
REQ-022 SHALL have port halted, output, 1 bit: state is HALT.

Function
REQ-023 SHALL implement states IDLE, FETCH, WAIT_MEM, ISSUE, EXEC, UPDATE, HALT.
REQ-024 IDLE: on start go to FETCH; otherwise hold.
REQ-025 FETCH: imem_req=1 and imem_addr=pc_curr for exactly one cycle, then go to WAIT_MEM.
REQ-026 WAIT_MEM: on imem_valid, register imem_rdata into instr and go to ISSUE; otherwise wait with no timeout.
REQ-027 SHALL ignore imem_valid in every state except WAIT_MEM.
REQ-028 ISSUE: instr_valid=1 with instr stable; on instr_ready go to EXEC.
REQ-029 EXEC: on exec_done, capture br_taken, br_offset and halt_req, then go to UPDATE.
REQ-030 UPDATE, halt not captured: pc_we=1 for one cycle, then go to FETCH.
REQ-031 In that UPDATE cycle, pc_next = pc_curr + br_offset (mod 2^PC_W) if br_taken, else pc_inc.
REQ-032 UPDATE, halt captured: pc_we=0 (PC stays on the halting instruction), then go to HALT.
REQ-033 halt_req and br_taken together: halt wins; no PC write.
REQ-034 HALT: SHALL be held until rst; start is ignored.
REQ-035 SHALL ignore start in every state except IDLE.
REQ-036 pc_we SHALL be asserted only in UPDATE.
REQ-037 When pc_we=0, pc_next SHALL equal pc_inc.
REQ-038 imem_addr SHALL equal pc_curr in all states.
REQ-039 Minimum loop SHALL be 5 cycles: FETCH at t; imem_valid at t+1; instr_ready at t+2; exec_done at t+3; pc_we at t+4; next FETCH at t+5 with the new pc_curr.
REQ-040 Wrap-around: pc_inc of 2^PC_W-1 wraps to 0; branch sums SHALL truncate to PC_W bits.

Reset
REQ-041 On rst: state=IDLE; pc_we, imem_req, instr_valid, busy, halted = 0; instr = 0; captured branch and halt registers = 0.
REQ-042 rst mid-operation SHALL abandon any outstanding read; a late imem_valid SHALL have no effect.
REQ-043 rst SHALL take priority over all other inputs in the same cycle.

Structure
REQ-044 A shared package cpu_pkg SHALL hold the fetch_state_t enum and the PC_W/INSTR_W default constants.
REQ-045 SHALL contain no sub-module; the branch target adder is inline; pc is instantiated beside fetch_ctrl at the CPU top, not inside it.

Verification
REQ-046 rst, start, imem returns 0xA5A5 one cycle after the request, ready and done immediate -> pc_we at cycle 4 with pc_next=1; instr=0xA5A5.
REQ-047 pc_curr=5, br_taken=1, br_offset=-3 (0x3FD) -> pc_next=2 with pc_we=1.
REQ-048 pc_curr=1023, no branch -> pc_next=0; and pc_curr=1020, br_offset=+8 -> pc_next=4.
REQ-049 halt_req=1 together with br_taken=1 -> pc_we stays 0, halted=1, busy=0; a later start does nothing.
REQ-050 imem_valid delayed 4 cycles and instr_ready delayed 3 cycles -> imem_req is a single pulse, instr_valid is held, instr is stable, and there is exactly one pc_we per instruction.
REQ-051 rst in WAIT_MEM, then imem_valid the next cycle -> state IDLE, instr_valid=0, instr=0.
